// File: rtl/braille_seq_pkg.sv
// Shared widths, state encoding and digit-enable codes for the Braille display sequencer.
package braille_seq_pkg;

  localparam int CELL_W = 6;
  localparam int SEG_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [1:0] DIG_HI  = 2'b10;
  localparam logic [1:0] DIG_LO  = 2'b01;
  localparam logic [1:0] DIG_OFF = 2'b00;

endpackage

// File: rtl/braille_cell_fifo.sv
// Small cell FIFO: naturally wrapping pointers, separate occupancy count, synchronous reset.
module braille_cell_fifo
  import braille_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [1:CELL_W]            din,
  output logic [1:CELL_W]            dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [1:CELL_W] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/braille_display_sequencer.sv
// Sequences buffered Braille cells through the external converter and multiplexes two digits.
//
//   state | meaning
//   IDLE  | display blank, waiting for a queued cell
//   LOAD  | cell presented to converter for one cycle, digit codes captured at the edge
//   SHOW  | captured codes shown for DWELL cycles, digits alternating every SCAN cycles
module braille_display_sequencer
  import braille_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DWELL = 1000,
  parameter int SCAN  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:CELL_W]   in_cell,
  output logic              in_ready,
  output logic [1:CELL_W]   conv_cell,
  input  logic [1:SEG_W]    conv_o1,
  input  logic [1:SEG_W]    conv_o0,
  output logic [1:SEG_W]    seg,
  output logic [1:0]        dig,
  output logic              busy,
  output logic              cell_done
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SC_W = (SCAN > 1) ? $clog2(SCAN) : 1;
  localparam int CN_W = $clog2(DEPTH) + 1;

  state_t            state, state_nxt;
  logic [DW_W-1:0]   dwell;
  logic [SC_W-1:0]   scan;
  logic              sel;
  logic [1:SEG_W]    hi, lo;
  logic              fifo_full, fifo_empty, pop, dwell_last;
  logic [CN_W-1:0]   fifo_count;
  logic [1:CELL_W]   head;

  braille_cell_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .din   (in_cell),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign in_ready   = !fifo_full;
  assign dwell_last = (dwell == DW_W'(DWELL - 1));

  // Next-state, pop and display decode; outputs derive from registers only.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    seg       = '0;
    dig       = DIG_OFF;
    cell_done = 1'b0;
    busy      = (state != IDLE) || (fifo_count != '0);
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SHOW;
      SHOW: begin
        seg       = sel ? hi : lo;
        dig       = sel ? DIG_HI : DIG_LO;
        cell_done = dwell_last;
        if (dwell_last) begin
          pop       = !fifo_empty;
          state_nxt = fifo_empty ? IDLE : LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, converter input, digit latches and dwell/scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      conv_cell <= '0;
      hi        <= '0;
      lo        <= '0;
      dwell     <= '0;
      scan      <= '0;
      sel       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) conv_cell <= head;
      if (state == LOAD) begin
        hi    <= conv_o1;
        lo    <= conv_o0;
        dwell <= '0;
        scan  <= '0;
        sel   <= 1'b1;
      end else if (state == SHOW) begin
        dwell <= dwell + DW_W'(1);
        if (scan == SC_W'(SCAN - 1)) begin
          scan <= '0;
          sel  <= ~sel;
        end else begin
          scan <= scan + SC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_braille_display_sequencer.sv
// Randomised and directed bench against a timeline model of the display sequencer.
module tb_braille_display_sequencer;

  localparam int DEPTH = 4;
  localparam int DWELL = 8;
  localparam int SCAN  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:6] in_cell = '0;
  logic       in_ready;
  logic [1:6] conv_cell;
  logic [1:7] conv_o1, conv_o0;
  logic [1:7] seg;
  logic [1:0] dig;
  logic       busy;
  logic       cell_done;

  braille_display_sequencer #(.DEPTH(DEPTH), .DWELL(DWELL), .SCAN(SCAN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_cell   (in_cell),
    .in_ready  (in_ready),
    .conv_cell (conv_cell),
    .conv_o1   (conv_o1),
    .conv_o0   (conv_o0),
    .seg       (seg),
    .dig       (dig),
    .busy      (busy),
    .cell_done (cell_done)
  );

  // Converter stand-in.
  assign conv_o1 = {1'b1, conv_cell};
  assign conv_o0 = {1'b0, ~conv_cell};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int e        = 0;

  // Model: queue of accepted cells, the cell last handed to the converter,
  // the edge at which it was fetched, and the earliest edge for the next fetch.
  logic [1:6] q[$];
  logic [1:6] cur = '0;
  int         last_pop = -100000;
  int         next_pop_ok = 0;
  bit         accepted;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, e);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:6] c);
    int         k;
    bit         show, hi_phase, was_full;
    logic [1:7] exp_seg;
    logic [1:0] exp_dig;
    rst = r; in_valid = v; in_cell = c;
    #1;
    if (!r) check("in_ready", 16'(in_ready), 16'(q.size() < DEPTH));
    accepted = 0;
    if (r) begin
      q.delete();
      cur = '0;
      last_pop = -100000;
      next_pop_ok = 0;
    end else begin
      was_full = (q.size() >= DEPTH);
      if (q.size() > 0 && e >= next_pop_ok) begin
        cur = q.pop_front();
        last_pop = e;
        next_pop_ok = e + DWELL + 1;
      end
      if (v && !was_full) begin
        q.push_back(c);
        accepted = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    k        = e - last_pop - 1;
    show     = (k >= 0) && (k < DWELL);
    hi_phase = ((k / SCAN) % 2) == 0;
    exp_dig  = !show ? 2'b00 : (hi_phase ? 2'b10 : 2'b01);
    exp_seg  = !show ? 7'b0 : (hi_phase ? {1'b1, cur} : {1'b0, ~cur});
    check("dig", 16'(dig), 16'(exp_dig));
    check("seg", 16'(seg), 16'(exp_seg));
    check("cell_done", 16'(cell_done), 16'(show && k == DWELL - 1));
    check("busy", 16'(busy), 16'(((e >= last_pop) && (e <= last_pop + DWELL)) || q.size() > 0));
    check("conv_cell", 16'(conv_cell), 16'(cur));
    e++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'($urandom));
  endtask

  // Holds in_valid with the given cell until the model accepts it.
  task automatic send(input logic [1:6] c);
    int budget = 100;
    do begin
      step(1'b0, 1'b1, c);
      budget--;
    end while (!accepted && budget > 0);
    if (!accepted) check("send_timeout", 16'(1), 16'(0));
  endtask

  task automatic drain();
    int budget = 2000;
    while ((q.size() > 0 || e <= last_pop + DWELL) && budget > 0) begin
      step(1'b0, 1'b0, '0);
      budget--;
    end
    if (budget == 0) check("drain_timeout", 16'(1), 16'(0));
  endtask

  initial begin
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 6'b111111);
    idle(20);

    // Single cell.
    send(6'b100000);
    idle(14);

    // Burst with in_valid held high; exercises full-with-pop.
    for (int i = 1; i <= 6; i++) send(6'(i));
    drain();
    idle(3);

    // Reset during the 4th SHOW cycle with two cells queued.
    send(6'b010101);
    send(6'b101010);
    send(6'b110011);
    while (e < last_pop + 4) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(20);

    // Pointer wrap with random gaps.
    for (int i = 0; i < 9; i++) begin
      send(6'($urandom));
      idle($urandom_range(0, 12));
    end
    drain();

    // Random traffic.
    for (int i = 0; i < 500; i++) step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom));
    drain();
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
